stopwatch_bcd: RTL and testbench

- 4-digit packed-BCD stopwatch/countdown timer with debounced start/stop and clear buttons.
- Produces the 16-bit value that feeds the four-digit multiplexed seven-segment driver on its `sw[15:0]` input; that driver consumes `value` directly.
- Format is SS.hh: seconds 00–59 on digits 3:2, hundredths 00–99 on digits 1:0.

---
 rtl/stopwatch_bcd.sv | 239 +++++++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: 4-digit packed-BCD stopwatch / countdown timer, format SS.hh.
//
// Parameters
//   TICK_DIV  clk cycles per hundredth (>= 2)
//   DEB_CYC   consecutive stable synchronized samples needed to accept a button level (>= 1)
//
// Ports
//   clk        single rising-edge clock
//   reset      asynchronous active-low reset
//   btn_start  raw button, each accepted press toggles run/stop
//   btn_clear  raw button, accepted press loads 0000 (up) or sanitized preset (down) and stops
//   dir        0 = count up, 1 = count down; sampled only while stopped
//   preset     packed BCD start value for down mode
//   value      registered packed BCD {d3,d2,d1,d0}, feeds the 7-segment driver sw[15:0]
//   running    counter active
//   done       one-cycle pulse when a countdown reaches 00.00
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned DEB_CYC  = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        dir,
  input  logic [15:0] preset,
  output logic [15:0] value,
  output logic        running,
  output logic        done
);

  localparam int unsigned DebW = $clog2(DEB_CYC + 1);
  localparam int unsigned PreW = $clog2(TICK_DIV);

  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYC);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StStop, StRun} state_e;

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd9) begin
      r[3:0] = r[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (r[7:4] != 4'd9) begin
        r[7:4] = r[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (r[11:8] != 4'd9) begin
          r[11:8] = r[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          // 59.99 wraps to 00.00; lower digits are already zero here
          if (r[15:12] < 4'd5) r[15:12] = r[15:12] + 4'd1;
          else                 r[15:12] = 4'd0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd0) begin
      r[3:0] = r[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) begin
        r[7:4] = r[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd9;
        if (r[11:8] != 4'd0) begin
          r[11:8] = r[11:8] - 4'd1;
        end else begin
          r[11:8] = 4'd9;
          // Only reachable from 00.00 if something went wrong; stay in range
          if (r[15:12] != 4'd0) r[15:12] = r[15:12] - 4'd1;
          else                  r[15:12] = 4'd5;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
    logic [15:0] r;
    r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    r[7:4]   = (v[7:4]   > 4'd9) ? 4'd9 : v[7:4];
    r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    r[15:12] = (v[15:12] > 4'd5) ? 4'd5 : v[15:12];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 = start, index 1 = clear
  // ---------------------------------------------------------------------------
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            act_q, act_d;
  logic [1:0][DebW-1:0]  cnt_q, cnt_d;

  assign btn_raw = {btn_clear, btn_start};

  always_comb begin
    deb_d = deb_q;
    act_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + DebW'(1) == DebLast) begin
        // Level held for DEB_CYC samples: accept it; only a rising edge acts
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
        act_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
    end
  end

  logic act_start, act_clear;
  assign act_start = act_q[0];
  assign act_clear = act_q[1];

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [15:0]     value_q, value_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            dir_q;
  logic            done_q, done_d;

  logic        tick;
  logic        step;
  logic        count_end;
  logic        start_blocked;
  logic [15:0] inc_val, dec_val;

  assign inc_val = bcd_inc(value_q);
  assign dec_val = bcd_dec(value_q);

  assign tick          = (state_q == StRun) && (pre_q == PreLast);
  // A start (stop) or clear on a tick cycle suppresses that count
  assign step          = tick && !act_start && !act_clear;
  assign count_end     = step && dir_q && (dec_val == 16'h0000);
  assign start_blocked = dir_q && (value_q == 16'h0000);

  // ---------------------------------------------------------------------------
  // Run/stop FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StStop;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StStop: begin
        if (act_start && !act_clear && !start_blocked) state_d = StRun;
      end
      StRun: begin
        if (act_clear || act_start || count_end) state_d = StStop;
      end
      default: state_d = StStop;
    endcase
  end

  always_comb begin
    running = (state_q == StRun);
  end

  // ---------------------------------------------------------------------------
  // Prescaler, value and done
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d = pre_q;
    if (act_clear) begin
      pre_d = '0;
    end else if (state_q == StRun) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
    end
  end

  always_comb begin
    value_d = value_q;
    if (act_clear) begin
      // Clear looks at the live dir input, not the latched one
      value_d = dir ? bcd_sanitize(preset) : 16'h0000;
    end else if (step) begin
      value_d = dir_q ? dec_val : inc_val;
    end
  end

  assign done_d = count_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      value_q <= 16'h0000;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      value_q <= value_d;
      done_q  <= done_d;
      if (state_q == StStop) dir_q <= dir;
    end
  end

  assign value = value_q;
  assign done  = done_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  logic        clk;
  logic        reset;
  logic        btn_start;
  logic        btn_clear;
  logic        dir;
  logic [15:0] preset;
  logic [15:0] value;
  logic        running;
  logic        done;

  int checks;
  int errors;

  stopwatch_bcd #(
    .TICK_DIV(4),
    .DEB_CYC (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .dir      (dir),
    .preset   (preset),
    .value    (value),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive buttons from the current negedge (cycle N) and return at N+6, where the
  // action has taken effect; buttons are released there.
  task automatic press(input logic s, input logic c);
    btn_start = s;
    btn_clear = c;
    cycles(6);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    dir       = 1'b0;
    preset    = 16'h0000;
    cycles(2);
    checks++;
    if ({value, running, done} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: value=%h running=%b done=%b expected 0000/0/0",
               value, running, done);
    end
    reset = 1'b1;
    cycles(3);
    checks++;
    if ({value, running} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: value=%h running=%b expected 0000/0", value, running);
    end
  endtask

  task automatic test_start_up();
    do_reset();
    dir = 1'b0;
    btn_start = 1'b1;              // cycle N
    cycles(5);                     // N+5
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL start_latency_early: running=%b expected 0", running);
    end
    cycles(1);                     // N+6
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: running=%b expected 1", running);
    end
    cycles(3);                     // N+9
    checks++;
    if (value !== 16'h0000) begin
      errors++;
      $display("FAIL up_before_tick: value=%h expected 0000", value);
    end
    cycles(1);                     // N+10
    btn_start = 1'b0;
    checks++;
    if (value !== 16'h0001) begin
      errors++;
      $display("FAIL up_first_tick: value=%h expected 0001", value);
    end
    cycles(3);                     // N+13
    checks++;
    if (value !== 16'h0001) begin
      errors++;
      $display("FAIL up_hold: value=%h expected 0001", value);
    end
    cycles(1);                     // N+14
    checks++;
    if (value !== 16'h0002) begin
      errors++;
      $display("FAIL up_second_tick: value=%h expected 0002", value);
    end
    cycles(6);                     // N+20, release already debounced
    checks++;
    if ({value, running} !== {16'h0003, 1'b1}) begin
      errors++;
      $display("FAIL release_no_action: value=%h running=%b expected 0003/1", value, running);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    dir    = 1'b1;
    preset = 16'h5998;
    press(1'b0, 1'b1);
    checks++;
    if ({value, running} !== {16'h5998, 1'b0}) begin
      errors++;
      $display("FAIL wrap_preset: value=%h running=%b expected 5998/0", value, running);
    end
    dir = 1'b0;
    cycles(6);
    press(1'b1, 1'b0);             // returns at N+6, running
    cycles(4);
    checks++;
    if (value !== 16'h5999) begin
      errors++;
      $display("FAIL wrap_carry: value=%h expected 5999", value);
    end
    cycles(4);
    checks++;
    if ({value, running, done} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_zero: value=%h running=%b done=%b expected 0000/1/0",
               value, running, done);
    end
  endtask

  task automatic test_countdown();
    do_reset();
    dir    = 1'b1;
    preset = 16'h0003;
    press(1'b0, 1'b1);
    checks++;
    if (value !== 16'h0003) begin
      errors++;
      $display("FAIL down_preset: value=%h expected 0003", value);
    end
    cycles(6);
    press(1'b1, 1'b0);             // N+6
    cycles(4);                     // N+10
    checks++;
    if (value !== 16'h0002) begin
      errors++;
      $display("FAIL down_step1: value=%h expected 0002", value);
    end
    cycles(4);                     // N+14
    checks++;
    if (value !== 16'h0001) begin
      errors++;
      $display("FAIL down_step2: value=%h expected 0001", value);
    end
    cycles(3);                     // N+17
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_early: done=%b expected 0", done);
    end
    cycles(1);                     // N+18
    checks++;
    if ({value, running, done} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL down_zero: value=%h running=%b done=%b expected 0000/0/1",
               value, running, done);
    end
    cycles(1);                     // N+19
    checks++;
    if ({value, done} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL done_width: value=%h done=%b expected 0000/0", value, done);
    end
    cycles(6);
    press(1'b1, 1'b0);
    cycles(4);
    checks++;
    if ({value, running} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL start_ignored: value=%h running=%b expected 0000/0", value, running);
    end
  endtask

  task automatic test_glitch_borrow();
    do_reset();
    dir = 1'b0;
    btn_start = 1'b1;
    cycles(2);
    btn_start = 1'b0;
    cycles(8);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rejected: running=%b expected 0", running);
    end
    dir    = 1'b1;
    preset = 16'h0100;
    cycles(1);
    press(1'b0, 1'b1);
    cycles(6);
    press(1'b1, 1'b0);
    checks++;
    if ({value, running} !== {16'h0100, 1'b1}) begin
      errors++;
      $display("FAIL borrow_start: value=%h running=%b expected 0100/1", value, running);
    end
    cycles(4);
    checks++;
    if (value !== 16'h0099) begin
      errors++;
      $display("FAIL borrow_step: value=%h expected 0099", value);
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    dir = 1'b0;
    press(1'b1, 1'b0);             // N+6, value 0000 running
    cycles(163);                   // N+169
    btn_start = 1'b1;
    btn_clear = 1'b1;
    cycles(5);                     // N+174, action cycle, no tick
    checks++;
    if ({value, running} !== {16'h0042, 1'b1}) begin
      errors++;
      $display("FAIL prio_before: value=%h running=%b expected 0042/1", value, running);
    end
    cycles(1);                     // N+175
    btn_start = 1'b0;
    btn_clear = 1'b0;
    checks++;
    if ({value, running} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL prio_running: value=%h running=%b expected 0000/0", value, running);
    end
    cycles(6);
    press(1'b1, 1'b1);             // both while stopped: clear must win
    cycles(4);
    checks++;
    if ({value, running} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL prio_stopped: value=%h running=%b expected 0000/0", value, running);
    end
    dir    = 1'b1;
    preset = 16'h7AF3;
    cycles(2);
    press(1'b0, 1'b1);
    checks++;
    if (value !== 16'h5993) begin
      errors++;
      $display("FAIL sanitize: value=%h expected 5993", value);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dir = 1'b0;
    press(1'b1, 1'b0);             // N+6
    cycles(68);                    // N+74
    checks++;
    if ({value, running} !== {16'h0017, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: value=%h running=%b expected 0017/1", value, running);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({value, running, done} !== {16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: value=%h running=%b done=%b expected 0000/0/0",
               value, running, done);
    end
    @(negedge clk);
    reset = 1'b1;
    cycles(20);
    checks++;
    if ({value, running} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset: value=%h running=%b expected 0000/0", value, running);
    end
    press(1'b1, 1'b0);
    cycles(4);
    checks++;
    if ({value, running} !== {16'h0001, 1'b1}) begin
      errors++;
      $display("FAIL restart: value=%h running=%b expected 0001/1", value, running);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_start_up();
    test_wrap();
    test_countdown();
    test_glitch_borrow();
    test_clear_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
